mgmt_hub: RTL and testbench
===========================

// Module: mgmt_hub
// PURPOSE
//  Single-master management-bus hub between mp_core mgmt port and N slave register blocks (sysreg, ram, pic, mdio, debug).
//  Decodes mgmt_adr to one slave, forwards one transaction at a time, returns a registered ack/read response.
//  Replaces the ad-hoc OR/one-hot response merge at system level.
//  Adds a response timeout, unmapped-address handling and sticky error flags.
// PARAMETERS
//  N_SLAVES  5             number of slave ports (1..2**SEL_W)
//  SEL_LO    8             lowest mgmt_adr bit of the slave-select field
//  SEL_W     3             width of slave-select field; slave = mgmt_adr[SEL_LO+SEL_W-1:SEL_LO]
//  TIMEOUT   255           max cycles waiting for slave ack or rxe (1..65535)
//  ERR_DATA  32'hDEADBEEF  read data returned on timeout or unmapped access
// PORTS
//  clk        in   1         system clock
//  rst        in   1         synchronous reset, active-high
//  mgmt_req   in   1         master request; held until mgmt_ack seen
//  mgmt_adr   in   32        master address
//  mgmt_rwn   in   1         1 = read, 0 = write
//  mgmt_wen   in   2         write half-word enables
//  mgmt_txd   in   32        write data
//  mgmt_ack   out  1         1-cycle accept pulse to master
//  mgmt_rxe   out  1         1-cycle read-data-valid pulse to master
//  mgmt_rxd   out  32        read data, valid with mgmt_rxe, else 0
//  s_req      out  N_SLAVES  per-slave request, one-hot or zero
//  s_adr      out  32        latched address to all slaves
//  s_rwn      out  1         latched rwn; s_wen out 2, s_txd out 32 likewise latched
//  s_ack      in   N_SLAVES  per-slave accept pulse
//  s_rxe      in   N_SLAVES  per-slave read-valid pulse
//  s_rxd      in   32*N      per-slave read data, slave i at [32*i+31:32*i]
//  err_clr    in   1         clears all sticky error flags
//  err_flags  out  3         sticky {proto, unmapped, timeout}
//  busy       out  1         high in any state but IDLE
// BEHAVIOUR
//  - Reset: state IDLE; mgmt_ack, mgmt_rxe, s_req, err_flags, busy = 0; mgmt_rxd = 0; s_adr/rwn/wen/txd = 0; counter = 0.
//  - States: IDLE, WAIT_ACK, WAIT_RD, ERR.
//  - IDLE: accept when mgmt_req && !mgmt_ack (suppresses re-accept on the ack cycle; master drops req after ack).
//    On accept, latch adr/rwn/wen/txd, clear counter; sel < N_SLAVES -> WAIT_ACK, s_req[sel]=1 next cycle;
//    sel >= N_SLAVES -> ERR, no s_req.
//  - WAIT_ACK: s_req held. On s_ack[sel]: s_req=0 and mgmt_ack=1 next cycle;
//    write -> IDLE; read with s_rxe[sel] same cycle -> mgmt_rxe=1, mgmt_rxd=slave data next cycle, -> IDLE;
//    read otherwise -> WAIT_RD.
//  - WAIT_RD: on s_rxe[sel], next cycle mgmt_rxe=1, mgmt_rxd=s_rxd[sel] -> IDLE.
//  - Latency: accept edge -> s_req +1 cycle; slave ack/rxe -> master ack/rxe +1 cycle (registered).
//  - Timeout: counter increments each cycle in WAIT_ACK/WAIT_RD and saturates; when counter == TIMEOUT, next cycle:
//    s_req=0, err_flags[0]=1, -> IDLE. From WAIT_ACK: mgmt_ack=1, plus mgmt_rxe=1/rxd=ERR_DATA if read.
//    From WAIT_RD: mgmt_rxe=1, rxd=ERR_DATA. A slave response in the same cycle as expiry wins; no error is flagged.
//  - ERR: one cycle; mgmt_ack=1 (+ mgmt_rxe=1, rxd=ERR_DATA if read) next cycle; err_flags[1]=1; -> IDLE.
//  - Proto error err_flags[2]=1 for any of:
//    s_ack/s_rxe from an unselected slave; any s_ack/s_rxe in IDLE or ERR (late reply after timeout);
//    s_ack in WAIT_RD. Offending pulses are otherwise ignored.
//  - err_clr: clears flags at the next edge; a same-cycle set wins over the clear.
//  - mgmt_ack and mgmt_rxe each high at most 1 cycle per transaction; at most one transaction outstanding.
//  - Reset mid-transaction: returns to IDLE next edge; pending s_req dropped; no response issued.
// TESTING
//  - Write sel=2, slave acks 3 cycles after s_req -> s_req=5'b00100 for 3 cycles, one mgmt_ack, no rxe, flags=0.
//  - Read sel=0, slave acks then rxe 4 cycles later with 32'h12345678 -> one mgmt_ack, later one mgmt_rxe with rxd=32'h12345678.
//  - Read with ack+rxe same cycle from sel=4 -> mgmt_ack and mgmt_rxe in the same cycle, +1 cycle latency.
//  - Read sel=6 (unmapped) -> no s_req, ack+rxe with 32'hDEADBEEF two cycles after accept, err_flags=3'b010.
//  - Read sel=1, slave never responds, TIMEOUT=8 -> ack+rxe with ERR_DATA, err_flags[0]=1; later stray s_ack[1] sets flag[2]; err_clr -> flags 0.
//  - Back-to-back: req held across ack -> exactly one transaction per req; rst during WAIT_RD -> outputs 0, IDLE.

Source files
------------

// File: rtl/mgmt_hub_if.sv
// rtl/mgmt_hub_if.sv - management bus and slave fan-out interfaces for mgmt_hub
`timescale 1ns/1ps

interface mgmt_hub_if;
    logic        mgmt_req;
    logic [31:0] mgmt_adr;
    logic        mgmt_rwn;
    logic [1:0]  mgmt_wen;
    logic [31:0] mgmt_txd;
    logic        mgmt_ack;
    logic        mgmt_rxe;
    logic [31:0] mgmt_rxd;

    modport master (
        output mgmt_req, mgmt_adr, mgmt_rwn, mgmt_wen, mgmt_txd,
        input  mgmt_ack, mgmt_rxe, mgmt_rxd
    );

    modport slave (
        input  mgmt_req, mgmt_adr, mgmt_rwn, mgmt_wen, mgmt_txd,
        output mgmt_ack, mgmt_rxe, mgmt_rxd
    );
endinterface

interface mgmt_slv_if #(
    parameter int N_SLAVES = 5
);
    logic [N_SLAVES-1:0]    s_req;
    logic [31:0]            s_adr;
    logic                   s_rwn;
    logic [1:0]             s_wen;
    logic [31:0]            s_txd;
    logic [N_SLAVES-1:0]    s_ack;
    logic [N_SLAVES-1:0]    s_rxe;
    logic [32*N_SLAVES-1:0] s_rxd;

    modport master (
        output s_req, s_adr, s_rwn, s_wen, s_txd,
        input  s_ack, s_rxe, s_rxd
    );

    modport slave (
        input  s_req, s_adr, s_rwn, s_wen, s_txd,
        output s_ack, s_rxe, s_rxd
    );
endinterface

// File: rtl/mgmt_hub.sv
// rtl/mgmt_hub.sv - single-master management hub with decode, timeout and sticky error flags
`timescale 1ns/1ps

module mgmt_hub #(
    parameter int          N_SLAVES = 5,
    parameter int          SEL_LO   = 8,
    parameter int          SEL_W    = 3,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic       clk,
    input  logic       rst,
    mgmt_hub_if.slave  m,
    mgmt_slv_if.master s,
    input  logic       err_clr,
    output logic [2:0] err_flags,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        WAIT_RD  = 2'd2,
        ERR      = 2'd3
    } state_t;

    state_t              state;
    logic [15:0]         cnt;
    logic [N_SLAVES-1:0] sel_oh;

    logic [SEL_W-1:0]    sel;
    logic [N_SLAVES-1:0] dec_oh;
    logic                mapped;
    logic [31:0]         rxd_sel;
    logic                ack_hit;
    logic                rxe_hit;
    logic                expired;
    logic                to_fire;
    logic                stray;
    logic [2:0]          err_set;

    assign sel     = m.mgmt_adr[SEL_LO +: SEL_W];
    assign ack_hit = |(s.s_ack & sel_oh);
    assign rxe_hit = |(s.s_rxe & sel_oh);
    // Compare with >= so that a read acked on the very last allowed cycle,
    // whose counter has already moved past TIMEOUT, still expires in WAIT_RD.
    assign expired = (cnt >= 16'(TIMEOUT));
    assign to_fire = ((state == WAIT_ACK) && !ack_hit && expired) ||
                     ((state == WAIT_RD)  && !rxe_hit && expired);
    assign err_set = {stray, (state == ERR), to_fire};
    assign busy    = (state != IDLE);

    // Decode the select field of the incoming address into a one-hot slave request.
    always_comb begin
        dec_oh = '0;
        mapped = 1'b0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel == SEL_W'(i)) begin
                dec_oh[i] = 1'b1;
                mapped    = 1'b1;
            end
        end
    end

    // Pick the read data lane of the slave that owns the current transaction.
    always_comb begin
        rxd_sel = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel_oh[i]) begin
                rxd_sel = s.s_rxd[32*i +: 32];
            end
        end
    end

    // Flag slave pulses that nobody is waiting for: wrong slave, wrong phase, or after a timeout.
    always_comb begin
        stray = 1'b0;
        case (state)
            IDLE, ERR: stray = (|s.s_ack) || (|s.s_rxe);
            WAIT_ACK:  stray = |((s.s_ack | s.s_rxe) & ~sel_oh);
            WAIT_RD:   stray = (|s.s_ack) || (|(s.s_rxe & ~sel_oh));
            default:   stray = 1'b0;
        endcase
    end

    // Transaction FSM with registered master responses, slave requests and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sel_oh     <= '0;
            m.mgmt_ack <= 1'b0;
            m.mgmt_rxe <= 1'b0;
            m.mgmt_rxd <= '0;
            s.s_req    <= '0;
            s.s_adr    <= '0;
            s.s_rwn    <= 1'b0;
            s.s_wen    <= '0;
            s.s_txd    <= '0;
            err_flags  <= '0;
        end else begin
            m.mgmt_ack <= 1'b0;
            m.mgmt_rxe <= 1'b0;
            m.mgmt_rxd <= '0;
            err_flags  <= (err_clr ? 3'b000 : err_flags) | err_set;

            case (state)
                IDLE: begin
                    // The ack cycle still sees the old request; do not take it twice.
                    if (m.mgmt_req && !m.mgmt_ack) begin
                        s.s_adr <= m.mgmt_adr;
                        s.s_rwn <= m.mgmt_rwn;
                        s.s_wen <= m.mgmt_wen;
                        s.s_txd <= m.mgmt_txd;
                        cnt     <= '0;
                        sel_oh  <= dec_oh;
                        if (mapped) begin
                            s.s_req <= dec_oh;
                            state   <= WAIT_ACK;
                        end else begin
                            state   <= ERR;
                        end
                    end
                end

                WAIT_ACK: begin
                    cnt <= (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
                    if (ack_hit) begin
                        s.s_req    <= '0;
                        m.mgmt_ack <= 1'b1;
                        if (!s.s_rwn) begin
                            state <= IDLE;
                        end else if (rxe_hit) begin
                            m.mgmt_rxe <= 1'b1;
                            m.mgmt_rxd <= rxd_sel;
                            state      <= IDLE;
                        end else begin
                            state <= WAIT_RD;
                        end
                    end else if (expired) begin
                        s.s_req    <= '0;
                        m.mgmt_ack <= 1'b1;
                        if (s.s_rwn) begin
                            m.mgmt_rxe <= 1'b1;
                            m.mgmt_rxd <= ERR_DATA;
                        end
                        state <= IDLE;
                    end
                end

                WAIT_RD: begin
                    cnt <= (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
                    if (rxe_hit) begin
                        m.mgmt_rxe <= 1'b1;
                        m.mgmt_rxd <= rxd_sel;
                        state      <= IDLE;
                    end else if (expired) begin
                        m.mgmt_rxe <= 1'b1;
                        m.mgmt_rxd <= ERR_DATA;
                        state      <= IDLE;
                    end
                end

                ERR: begin
                    m.mgmt_ack <= 1'b1;
                    if (s.s_rwn) begin
                        m.mgmt_rxe <= 1'b1;
                        m.mgmt_rxd <= ERR_DATA;
                    end
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mgmt_hub.sv
// tb/tb_mgmt_hub.sv - scoreboard testbench for mgmt_hub
`timescale 1ns/1ps

module tb_mgmt_hub;

    localparam int          NS    = 5;
    localparam int          TO    = 8;
    localparam int          NV    = 1000;
    localparam logic [31:0] ERR_D = 32'hDEADBEEF;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       err_clr = 1'b0;
    logic [2:0] err_flags;
    logic       busy;

    mgmt_hub_if                   m ();
    mgmt_slv_if #(.N_SLAVES(NS))  s ();

    mgmt_hub #(
        .N_SLAVES (NS),
        .SEL_LO   (8),
        .SEL_W    (3),
        .TIMEOUT  (TO),
        .ERR_DATA (ERR_D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m         (m),
        .s         (s),
        .err_clr   (err_clr),
        .err_flags (err_flags),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          ack;
        bit          rxe;
        logic [31:0] rxd;
        int          at;
    } ev_t;

    typedef struct {
        int            idx;
        logic [NS-1:0] oh;
        logic [31:0]   adr;
        bit            rwn;
        logic [1:0]    wen;
        logic [31:0]   txd;
        int            ad;
        int            rd;
        logic [31:0]   data;
    } sl_t;

    ev_t           sbq[$];
    sl_t           slq[$];
    logic [2:0]    exp_flags  = 3'b000;
    int            n_chk      = 0;
    int            n_fail     = 0;
    int            stray_cnt  = 0;
    int            stray_seen = 0;
    logic [NS-1:0] stray_mask = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input bit ack, input bit rxe, input logic [31:0] rxd, input int at);
        ev_t e;
        e.ack = ack;
        e.rxe = rxe;
        e.rxd = rxd;
        e.at  = at;
        sbq.push_back(e);
    endtask

    // Monitor: every master-side response is popped from the scoreboard and compared.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (m.mgmt_ack || m.mgmt_rxe) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_resp", 64'({m.mgmt_ack, m.mgmt_rxe}), 64'(0));
                    end else begin
                        e = sbq.pop_front();
                        check("resp_ack",   64'(m.mgmt_ack), 64'(e.ack));
                        check("resp_rxe",   64'(m.mgmt_rxe), 64'(e.rxe));
                        check("resp_rxd",   64'(m.mgmt_rxd), 64'(e.rxd));
                        check("resp_cycle", 64'(cyc),        64'(e.at));
                    end
                end else begin
                    check("idle_rxd", 64'(m.mgmt_rxd), 64'(0));
                end
            end
        end
    end

    // Slave model: answers the selected request with the planned delays, noise on other lanes.
    initial begin
        sl_t t;
        bit  act  = 1'b0;
        int  j    = 0;
        int  held = 0;
        s.s_ack = '0;
        s.s_rxe = '0;
        s.s_rxd = '0;
        forever begin
            @(negedge clk);
            s.s_ack = '0;
            s.s_rxe = '0;
            s.s_rxd = {$urandom, $urandom, $urandom, $urandom, $urandom};
            if (rst) begin
                act = 1'b0;
            end else begin
                if (!act && s.s_req != '0) begin
                    if (slq.size() == 0) begin
                        check("unexpected_s_req", 64'(s.s_req), 64'(0));
                    end else begin
                        t    = slq.pop_front();
                        act  = 1'b1;
                        j    = 0;
                        held = 0;
                        check("s_req_onehot", 64'(s.s_req), 64'(t.oh));
                        check("s_adr",        64'(s.s_adr), 64'(t.adr));
                        check("s_rwn",        64'(s.s_rwn), 64'(t.rwn));
                        check("s_wen",        64'(s.s_wen), 64'(t.wen));
                        check("s_txd",        64'(s.s_txd), 64'(t.txd));
                    end
                end
                if (act) begin
                    if (s.s_req == t.oh) held++;
                    if (j == t.ad) s.s_ack = t.oh;
                    if (t.rwn && t.ad != NV && t.rd != NV && j == t.ad + t.rd) begin
                        s.s_rxe = t.oh;
                        s.s_rxd[32*t.idx +: 32] = t.data;
                    end
                    j++;
                    if (j == TO + 3) begin
                        check("s_req_held", 64'(held), 64'((t.ad == NV) ? TO + 1 : t.ad + 1));
                        act = 1'b0;
                    end
                end else if (stray_seen != stray_cnt) begin
                    s.s_ack = stray_mask;
                    stray_seen++;
                end
            end
        end
    end

    // One master transaction; mode 1 pulses err_clr during it, mode 2 resets after the ack.
    task automatic do_txn(input int sel, input bit rwn, input int ad, input int rd,
                          input logic [31:0] data, input int mode);
        logic [31:0] adr;
        logic [1:0]  wen;
        logic [31:0] txd;
        logic [2:0]  ef;
        int          a;
        bit          got;
        sl_t         t;
        adr       = $urandom;
        adr[10:8] = 3'(sel);
        wen       = 2'($urandom);
        txd       = $urandom;
        ef        = 3'b000;
        if (sel < NS) begin
            t.idx  = sel;
            t.oh   = NS'(1) << sel;
            t.adr  = adr;
            t.rwn  = rwn;
            t.wen  = wen;
            t.txd  = txd;
            t.ad   = ad;
            t.rd   = rd;
            t.data = data;
            slq.push_back(t);
        end
        @(negedge clk);
        m.mgmt_adr = adr;
        m.mgmt_rwn = rwn;
        m.mgmt_wen = wen;
        m.mgmt_txd = txd;
        m.mgmt_req = 1'b1;
        @(posedge clk);
        #1;
        a = cyc;
        if (mode == 1) err_clr = 1'b1;
        if (sel >= NS) begin
            push_ev(1'b1, rwn, rwn ? ERR_D : 32'h0, a + 1);
            ef = 3'b010;
        end else if (ad == NV) begin
            push_ev(1'b1, rwn, rwn ? ERR_D : 32'h0, a + TO + 1);
            ef = 3'b001;
        end else if (!rwn) begin
            push_ev(1'b1, 1'b0, 32'h0, a + ad + 1);
        end else if (rd == 0) begin
            push_ev(1'b1, 1'b1, data, a + ad + 1);
        end else begin
            push_ev(1'b1, 1'b0, 32'h0, a + ad + 1);
            if (rd == NV) begin
                push_ev(1'b0, 1'b1, ERR_D, a + TO + 1);
                ef = 3'b001;
            end else begin
                push_ev(1'b0, 1'b1, data, a + ad + rd + 1);
            end
        end
        if (mode == 1) begin
            @(posedge clk);
            #1;
            err_clr = 1'b0;
        end
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (m.mgmt_ack) got = 1'b1;
        end
        check("ack_seen", 64'(got), 64'(1));
        // Hold req through the ack cycle's closing edge to exercise re-accept suppression.
        @(posedge clk);
        #1;
        m.mgmt_req = 1'b0;
        if (mode == 2) begin
            check("busy_in_wait_rd", 64'(busy), 64'(1));
            rst = 1'b1;
            @(posedge clk);
            #1;
            check("rst_mid_ack",   64'(m.mgmt_ack), 64'(0));
            check("rst_mid_rxe",   64'(m.mgmt_rxe), 64'(0));
            check("rst_mid_rxd",   64'(m.mgmt_rxd), 64'(0));
            check("rst_mid_s_req", 64'(s.s_req),    64'(0));
            check("rst_mid_busy",  64'(busy),       64'(0));
            check("rst_mid_flags", 64'(err_flags),  64'(0));
            rst = 1'b0;
            sbq.delete();
            exp_flags = 3'b000;
            ef        = 3'b000;
        end
        while (cyc < a + TO + 4) @(posedge clk);
        #1;
        if (mode == 1) exp_flags = ef;
        else           exp_flags = exp_flags | ef;
        check("err_flags",  64'(err_flags),  64'(exp_flags));
        check("sb_drained", 64'(sbq.size()), 64'(0));
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr   = 1'b0;
        exp_flags = 3'b000;
        check("err_clr", 64'(err_flags), 64'(0));
    endtask

    // Stimulus: directed cases first, then randomized traffic, then reset mid-transaction.
    initial begin
        int sel;
        bit rwn;
        int ad;
        int rd;
        m.mgmt_req = 1'b0;
        m.mgmt_adr = '0;
        m.mgmt_rwn = 1'b0;
        m.mgmt_wen = '0;
        m.mgmt_txd = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack",   64'(m.mgmt_ack), 64'(0));
        check("rst_rxe",   64'(m.mgmt_rxe), 64'(0));
        check("rst_rxd",   64'(m.mgmt_rxd), 64'(0));
        check("rst_s_req", 64'(s.s_req),    64'(0));
        check("rst_s_adr", 64'(s.s_adr),    64'(0));
        check("rst_s_txd", 64'(s.s_txd),    64'(0));
        check("rst_flags", 64'(err_flags),  64'(0));
        check("rst_busy",  64'(busy),       64'(0));
        rst = 1'b0;
        repeat (2) @(posedge clk);

        do_txn(2, 1'b0, 2,  NV, 32'h0,        0);
        do_txn(0, 1'b1, 0,  4,  32'h12345678, 0);
        do_txn(4, 1'b1, 1,  0,  $urandom,     0);
        do_txn(6, 1'b1, 0,  0,  32'h0,        0);
        pulse_clr();
        do_txn(1, 1'b1, NV, NV, 32'h0,        0);
        do_txn(1, 1'b0, NV, NV, 32'h0,        0);
        do_txn(3, 1'b1, TO, 0,  $urandom,     0);
        do_txn(3, 1'b0, TO, NV, 32'h0,        0);

        stray_mask = NS'(5'b00010);
        stray_cnt++;
        repeat (3) @(negedge clk);
        exp_flags = exp_flags | 3'b100;
        check("stray_flag", 64'(err_flags), 64'(exp_flags));

        do_txn(7, 1'b0, 0, 0, 32'h0, 1);
        pulse_clr();

        for (int n = 0; n < 150; n++) begin
            sel = int'($urandom % 8);
            rwn = 1'($urandom);
            ad  = ($urandom % 6 == 0) ? NV : int'($urandom_range(0, TO));
            if (ad == NV)                 rd = NV;
            else if (ad == TO)            rd = 0;
            else if ($urandom % 5 == 0)   rd = NV;
            else                          rd = int'($urandom_range(0, TO - ad));
            do_txn(sel, rwn, ad, rd, $urandom, 0);
            if ($urandom % 10 == 0) pulse_clr();
        end

        do_txn(0, 1'b1, 0, NV, $urandom, 2);
        repeat (5) @(posedge clk);
        #1;
        check("final_busy",  64'(busy),       64'(0));
        check("final_slq",   64'(slq.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
